// File: rtl/calc_pkg.sv
// Shared definitions for the result display block.
//   state_t        converter FSM states (IDLE, SHIFT, COMMIT)
//   SEG_*          active-low seven-segment patterns, bit order {g,f,e,d,c,b,a}
//   DIG_MINUS/E    out-of-range digit codes understood by seg7_decode
package calc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_COMMIT
  } state_t;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  localparam logic [6:0] SEG_E     = 7'b0000110;

  // Digit codes above 9 reused for the non-numeric glyphs.
  localparam logic [3:0] DIG_MINUS = 4'hA;
  localparam logic [3:0] DIG_E     = 4'hE;

endpackage

// File: rtl/seg7_decode.sv
// Combinational seven-segment decoder.
//   digit  in   4-bit digit code (0-9, DIG_MINUS, DIG_E)
//   blank  in   1 forces all segments off
//   seg    out  active-low segments {g,f,e,d,c,b,a}
import calc_pkg::*;

module seg7_decode (
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (!blank) begin
      case (digit)
        4'd0:      seg = SEG_0;
        4'd1:      seg = SEG_1;
        4'd2:      seg = SEG_2;
        4'd3:      seg = SEG_3;
        4'd4:      seg = SEG_4;
        4'd5:      seg = SEG_5;
        4'd6:      seg = SEG_6;
        4'd7:      seg = SEG_7;
        4'd8:      seg = SEG_8;
        4'd9:      seg = SEG_9;
        DIG_MINUS: seg = SEG_MINUS;
        DIG_E:     seg = SEG_E;
        default:   seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/result_display.sv
// Signed result to 4-digit multiplexed seven-segment display.
// A double-dabble converter turns a captured signed result into BCD and
// commits it to the display registers; an independent scanner cycles the
// four digits from those registers.
//   clk      in   system clock
//   reset_n  in   asynchronous active-low reset
//   load     in   capture result (ignored while busy)
//   result   in   W-bit signed value
//   busy     out  conversion in progress
//   valid    out  display registers hold a completed conversion
//   an       out  active-low one-hot digit enable, an[3] leftmost
//   seg      out  active-low segments {g,f,e,d,c,b,a}
import calc_pkg::*;

module result_display #(
  parameter int W           = 10,
  parameter int REFRESH_DIV = 50000
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] result,
  output logic         busy,
  output logic         valid,
  output logic [3:0]   an,
  output logic [6:0]   seg
);

  // Every 3 binary bits need at most one decimal digit; keep at least the
  // hundreds/tens/units nibbles so the commit slice is always in range.
  localparam int ND = ((W / 3 + 1) < 3) ? 3 : (W / 3 + 1);
  localparam int BW = 4 * ND;
  localparam int CW = $clog2(W + 1);
  localparam int RW = $clog2(REFRESH_DIV);

  localparam logic [CW-1:0] ITERS    = CW'(W);
  localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_DIV - 1);

  state_t state, state_next;

  // Converter
  logic [BW-1:0] bcd, bcd_adj;
  logic [W-1:0]  bin;
  logic [CW-1:0] iter;
  logic          neg_cap, err_cap;
  logic [W-1:0]  mag;
  logic          mag_err;

  // Display registers (the only state shared with the scanner)
  logic [3:0]    disp_h, disp_t, disp_u;
  logic          disp_neg, disp_err;

  // Scanner
  logic [RW-1:0] refresh;
  logic [1:0]    idx;
  logic [3:0]    cur_digit;
  logic          cur_blank;
  logic [6:0]    cur_seg;

  assign mag     = result[W-1] ? (~result + 1'b1) : result;
  assign mag_err = (W > 10) && (32'(mag) > 32'd999);

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (load) state_next = ST_SHIFT;
      ST_SHIFT:  if (iter == CW'(1)) state_next = ST_COMMIT;
      ST_COMMIT: state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  assign busy = (state != ST_IDLE);

  // Double-dabble correction: +3 on every nibble >= 5 before the shift.
  always_comb begin
    bcd_adj = bcd;
    for (int unsigned i = 0; i < ND; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bcd      <= '0;
      bin      <= '0;
      iter     <= '0;
      neg_cap  <= 1'b0;
      err_cap  <= 1'b0;
      disp_h   <= '0;
      disp_t   <= '0;
      disp_u   <= '0;
      disp_neg <= 1'b0;
      disp_err <= 1'b0;
      valid    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (load) begin
            neg_cap <= result[W-1];
            err_cap <= mag_err;
            bin     <= mag;
            bcd     <= '0;
            iter    <= ITERS;
          end
        end
        ST_SHIFT: begin
          bcd  <= {bcd_adj[BW-2:0], bin[W-1]};
          bin  <= {bin[W-2:0], 1'b0};
          iter <= iter - 1'b1;
        end
        ST_COMMIT: begin
          disp_u   <= bcd[3:0];
          disp_t   <= bcd[7:4];
          disp_h   <= bcd[11:8];
          disp_neg <= neg_cap;
          disp_err <= err_cap;
          valid    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Refresh divider and digit index
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      refresh <= '0;
      idx     <= '0;
    end else if (refresh == REF_LAST) begin
      refresh <= '0;
      idx     <= idx + 2'd1;
    end else begin
      refresh <= refresh + 1'b1;
    end
  end

  // Leading-zero blanking: tens blank only when hundreds is also zero.
  always_comb begin
    cur_digit = disp_u;
    cur_blank = 1'b0;
    case (idx)
      2'd3: begin
        cur_digit = DIG_MINUS;
        cur_blank = !disp_neg;
      end
      2'd2: begin
        cur_digit = disp_err ? DIG_E : disp_h;
        cur_blank = !disp_err && (disp_h == 4'd0);
      end
      2'd1: begin
        cur_digit = disp_err ? DIG_E : disp_t;
        cur_blank = !disp_err && (disp_h == 4'd0) && (disp_t == 4'd0);
      end
      default: begin
        cur_digit = disp_err ? DIG_E : disp_u;
        cur_blank = 1'b0;
      end
    endcase
  end

  seg7_decode u_decode (
    .digit (cur_digit),
    .blank (cur_blank),
    .seg   (cur_seg)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      an  <= 4'b1111;
      seg <= SEG_BLANK;
    end else if (valid) begin
      an  <= ~(4'b0001 << idx);
      seg <= cur_seg;
    end else begin
      an  <= 4'b1111;
      seg <= SEG_BLANK;
    end
  end

endmodule
